// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer and its prescaler.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  localparam int TIME_50MHZ = 24999999 + 1;
  localparam int TIME_SIM   = 5;

  localparam logic ONE_SHOT = 1'b0;
  localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts enabled cycles 0..CLK_DIV-1 and flags the last one.
module tick_prescaler #(
  parameter int CLK_DIV = 25000000,
  parameter int DIV_W   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign wrap = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Loadable base-tick down-counter with one-shot/periodic modes, pause, abort and retrigger.
module interval_timer
  import timer_pkg::*;
#(
  parameter int CLK_DIV = TIME_50MHZ,
  parameter int DIV_W   = 32,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  input  logic             mode,
  input  logic             pause,
  input  logic             abort,
  output logic             tick_out,
  output logic             expired,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             expired_q, expired_d;
  logic             busy_q, busy_d;

  logic             presc_clr;
  logic             count_en;
  logic             wrap;

  // Counting happens in RUN, and also in the PAUSED cycle where pause drops,
  // so each paused cycle costs exactly one cycle of interval.
  assign presc_clr = abort || start;
  assign count_en  = !abort && !start && !pause && (state_q != IDLE);

  tick_prescaler #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (count_en),
    .wrap (wrap)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    mode_d      = mode_q;
    tick_d      = 1'b0;
    expired_d   = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start) begin
      if (load_val != '0) begin
        state_d     = RUN;
        remaining_d = load_val;
        reload_d    = load_val;
        mode_d      = mode;
      end else begin
        state_d     = IDLE;
        remaining_d = '0;
        expired_d   = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (wrap) begin
        tick_d = 1'b1;
        if (remaining_q > CNT_W'(1)) begin
          remaining_d = remaining_q - CNT_W'(1);
        end else begin
          expired_d = 1'b1;
          if (mode_q == PERIODIC) begin
            remaining_d = reload_q;
          end else begin
            remaining_d = '0;
            state_d     = IDLE;
          end
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      mode_q      <= ONE_SHOT;
      tick_q      <= 1'b0;
      expired_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      mode_q      <= mode_d;
      tick_q      <= tick_d;
      expired_q   <= expired_d;
      busy_q      <= busy_d;
    end
  end

  assign tick_out  = tick_q;
  assign expired   = expired_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;

endmodule
